fifo_byte_serializer: RTL

FIFO_BYTE_SERIALIZER -- requirements
Module: fifo_byte_serializer

---
 rtl/fifo_byte_serializer.sv | 85 ++++++++
 1 files changed

// File: rtl/fifo_byte_serializer.sv
// Reads 32-bit words from an upstream FIFO and streams them out one byte at a time
// over a valid/ready handshake, counting every word whose four bytes were all accepted.
module fifo_byte_serializer #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        EN,
  input  logic        fifoEmpty,
  input  logic [31:0] fifoData,
  output logic        fifoRD,
  output logic [7:0]  outData,
  output logic        outValid,
  input  logic        outReady,
  output logic        busy,
  output logic [15:0] wordCount
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StSend} state_e;

  state_e      r_state;
  state_e      w_state_next;
  logic        r_fifo_rd;
  logic [31:0] r_shift;
  logic [1:0]  r_idx;
  logic [15:0] r_word_count;
  logic [15:0] w_word_count_next;
  logic        w_start;
  logic        w_accept;
  logic        w_last;

  assign w_start           = EN & ~fifoEmpty;
  assign w_accept          = (r_state == StSend) & outReady;
  assign w_last            = w_accept & (r_idx == 2'd3);
  assign w_word_count_next = w_last ? r_word_count + 16'd1 : r_word_count;

  // State register; fifoRD is registered so it is high exactly while in StReq.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_state   <= StIdle;
      r_fifo_rd <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_fifo_rd <= (w_state_next == StReq);
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_shift      <= 32'h0;
      r_idx        <= 2'd0;
      r_word_count <= 16'h0;
    end else begin
      r_word_count <= w_word_count_next;
      if (r_state == StWait) begin
        r_shift <= fifoData;
        r_idx   <= 2'd0;
      end else if (w_accept) begin
        // The byte on outData always sits at the outgoing end of the shift register.
        r_shift <= MSB_FIRST ? {r_shift[23:0], 8'h00} : {8'h00, r_shift[31:8]};
        r_idx   <= r_idx + 2'd1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: if (w_start) w_state_next = StReq;
      StReq:  w_state_next = StWait;
      StWait: w_state_next = StSend;
      StSend: if (w_last) w_state_next = w_start ? StReq : StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    fifoRD    = r_fifo_rd;
    outValid  = (r_state == StSend);
    busy      = (r_state != StIdle);
    outData   = MSB_FIRST ? r_shift[31:24] : r_shift[7:0];
    wordCount = r_word_count;
  end

endmodule
